// File: rtl/layer_stack_pkg.sv
// Shared pixel definitions for the paint pipeline: color width, the transparent
// color, and a small opacity helper used by the compositor.
package layer_stack_pkg;

  localparam int COLOR_WIDTH = 8;
  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE = {COLOR_WIDTH{1'b0}};

  function automatic logic is_opaque(input logic [COLOR_WIDTH-1:0] color);
    return (color != COLOR_NONE);
  endfunction

endpackage

// File: rtl/layer_stack_memory.sv
// One canvas layer: a synchronous write port and a registered read port.
// A read and a write to the same address at the same edge return the old data.
module layer_memory #(
  parameter int DEPTH = 307200,
  parameter int AW    = 19,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Storage is deliberately left unreset; the clear sweep owns initialisation.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/layer_stack.sv
// Multi-layer canvas store: tool writes into the active layer, a per-layer clear
// sweep, and a two-stage top-most-opaque compositor for the VGA read path.
module layer_stack
  import layer_stack_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int NUM_LAYERS = 4,
  localparam int XW    = $clog2(WIDTH),
  localparam int YW    = $clog2(HEIGHT),
  localparam int LW    = $clog2(NUM_LAYERS),
  localparam int DEPTH = WIDTH * HEIGHT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LW-1:0]          active_layer,
  input  logic [NUM_LAYERS-1:0]  layer_visible,
  input  logic                   tool_valid,
  input  logic [XW-1:0]          tool_x,
  input  logic [YW-1:0]          tool_y,
  input  logic [COLOR_WIDTH-1:0] tool_color,
  input  logic                   clear_req,
  input  logic [LW-1:0]          clear_layer,
  output logic                   clear_busy,
  input  logic [XW-1:0]          read_x,
  input  logic [YW-1:0]          read_y,
  output logic [COLOR_WIDTH-1:0] pixel_color,
  output logic                   pixel_opaque,
  output logic [LW-1:0]          top_layer
);

  localparam logic [XW:0]   X_LIM     = (XW+1)'(WIDTH);
  localparam logic [YW:0]   Y_LIM     = (YW+1)'(HEIGHT);
  localparam logic [LW:0]   L_LIM     = (LW+1)'(NUM_LAYERS);
  localparam logic [AW-1:0] W_MUL     = AW'(WIDTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * W_MUL + AW'(x);
  endfunction

  clr_state_e                         r_state;
  logic [AW-1:0]                      r_cnt;
  logic [LW-1:0]                      r_clr_layer;
  logic                               r_busy;
  logic [NUM_LAYERS-1:0]              r_vis;
  logic                               r_rd_ok;
  logic [COLOR_WIDTH-1:0]             r_pix_color;
  logic                               r_pix_opaque;
  logic [LW-1:0]                      r_top_layer;

  logic                               w_tool_in_range;
  logic                               w_tool_we;
  logic [AW-1:0]                      w_tool_addr;
  logic                               w_clr_accept;
  logic                               w_rd_ok;
  logic [AW-1:0]                      w_rd_addr;
  logic [NUM_LAYERS-1:0][COLOR_WIDTH-1:0] w_rdata;
  logic [COLOR_WIDTH-1:0]             w_color;
  logic                               w_opaque;
  logic [LW-1:0]                      w_top;

  assign w_tool_in_range = ({1'b0, tool_x} < X_LIM) && ({1'b0, tool_y} < Y_LIM);
  assign w_tool_we       = tool_valid && w_tool_in_range && ({1'b0, active_layer} < L_LIM)
                           && layer_visible[active_layer];
  assign w_tool_addr     = pix_addr(tool_x, tool_y);
  assign w_clr_accept    = clear_req && ({1'b0, clear_layer} < L_LIM);
  assign w_rd_ok         = ({1'b0, read_x} < X_LIM) && ({1'b0, read_y} < Y_LIM);
  assign w_rd_addr       = pix_addr(read_x, read_y);

  // Clear sweep FSM: one address per cycle; requests during a sweep are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {AW{1'b0}};
      r_clr_layer <= {LW{1'b0}};
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_clr_accept) begin
            r_state     <= ST_CLEAR;
            r_cnt       <= {AW{1'b0}};
            r_clr_layer <= clear_layer;
            r_busy      <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_IDLE;
            r_cnt   <= {AW{1'b0}};
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= {AW{1'b0}};
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    logic                   w_clr_hit;
    logic                   w_we;
    logic [AW-1:0]          w_waddr;
    logic [COLOR_WIDTH-1:0] w_wdata;

    // The sweep owns the write port of the layer it clears; tool writes there are lost.
    always_comb begin
      w_clr_hit = (r_state == ST_CLEAR) && (r_clr_layer == LW'(g));
      if (w_clr_hit) begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = COLOR_NONE;
      end else begin
        w_we    = w_tool_we && (active_layer == LW'(g));
        w_waddr = w_tool_addr;
        w_wdata = tool_color;
      end
    end

    layer_memory #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (COLOR_WIDTH)
    ) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rdata[g])
    );
  end

  // Stage-1 side band: visibility and range travel alongside the memory read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vis   <= {NUM_LAYERS{1'b0}};
      r_rd_ok <= 1'b0;
    end else begin
      r_vis   <= layer_visible;
      r_rd_ok <= w_rd_ok;
    end
  end

  // Later (higher) layers overwrite earlier picks, so the top-most opaque layer wins.
  always_comb begin
    w_color  = COLOR_NONE;
    w_opaque = 1'b0;
    w_top    = {LW{1'b0}};
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (r_rd_ok && r_vis[i] && is_opaque(w_rdata[i])) begin
        w_color  = w_rdata[i];
        w_opaque = 1'b1;
        w_top    = LW'(i);
      end else begin
        w_color  = w_color;
      end
    end
  end

  // Stage-2 output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_color  <= COLOR_NONE;
      r_pix_opaque <= 1'b0;
      r_top_layer  <= {LW{1'b0}};
    end else begin
      r_pix_color  <= w_color;
      r_pix_opaque <= w_opaque;
      r_top_layer  <= w_top;
    end
  end

  assign clear_busy   = r_busy;
  assign pixel_color  = r_pix_color;
  assign pixel_opaque = r_pix_opaque;
  assign top_layer    = r_top_layer;

endmodule

// File: tb/tb_layer_stack.sv
// Directed bench for layer_stack at 8x8 with 4 layers: table-driven reads plus
// hand-written sequences for pipelining, clear sweeps and reset mid-sweep.
module tb_layer_stack;
  import layer_stack_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [1:0]             active_layer;
  logic [3:0]             layer_visible;
  logic                   tool_valid;
  logic [2:0]             tool_x, tool_y;
  logic [COLOR_WIDTH-1:0] tool_color;
  logic                   clear_req;
  logic [1:0]             clear_layer;
  logic                   clear_busy;
  logic [2:0]             read_x, read_y;
  logic [COLOR_WIDTH-1:0] pixel_color;
  logic                   pixel_opaque;
  logic [1:0]             top_layer;

  int n_checks = 0;
  int n_pass   = 0;

  layer_stack #(.WIDTH(8), .HEIGHT(8), .NUM_LAYERS(4)) dut (
    .clk(clk), .reset(reset), .active_layer(active_layer), .layer_visible(layer_visible),
    .tool_valid(tool_valid), .tool_x(tool_x), .tool_y(tool_y), .tool_color(tool_color),
    .clear_req(clear_req), .clear_layer(clear_layer), .clear_busy(clear_busy),
    .read_x(read_x), .read_y(read_y), .pixel_color(pixel_color),
    .pixel_opaque(pixel_opaque), .top_layer(top_layer)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    logic [3:0] vis;
    int         ec;
    int         eo;
    int         et;
  } rd_vec_t;

  rd_vec_t vecs[9];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int l, input int x, input int y, input int c);
    active_layer = 2'(l);
    tool_x       = 3'(x);
    tool_y       = 3'(y);
    tool_color   = COLOR_WIDTH'(c);
    tool_valid   = 1'b1;
    tick();
    tool_valid   = 1'b0;
  endtask

  task automatic check_px(input string name, input int x, input int y, input logic [3:0] vis,
                          input int ec, input int eo, input int et);
    read_x        = 3'(x);
    read_y        = 3'(y);
    layer_visible = vis;
    tick();
    tick();
    check({name, "_color"},  int'(pixel_color),  ec);
    check({name, "_opaque"}, int'(pixel_opaque), eo);
    check({name, "_top"},    int'(top_layer),    et);
  endtask

  task automatic clear_wait(input int l);
    int cnt;
    clear_layer = 2'(l);
    clear_req   = 1'b1;
    tick();
    clear_req   = 1'b0;
    cnt = 0;
    while (clear_busy && cnt < 200) begin
      cnt++;
      tick();
    end
    check($sformatf("clear%0d_done", l), int'(clear_busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int nonzero;
    int exp_c[4];
    int exp_x[4];
    int exp_y[4];
    int exp_t[4];

    vecs[0] = '{3, 2, 4'hF, 5, 1, 1};
    vecs[1] = '{4, 2, 4'hF, 0, 0, 0};
    vecs[2] = '{1, 1, 4'hF, 6, 1, 3};
    vecs[3] = '{1, 1, 4'h7, 2, 1, 0};
    vecs[4] = '{1, 1, 4'h6, 0, 0, 0};
    vecs[5] = '{5, 5, 4'hF, 0, 0, 0};
    vecs[6] = '{6, 6, 4'hF, 9, 1, 2};
    vecs[7] = '{6, 6, 4'hB, 0, 0, 0};
    vecs[8] = '{3, 2, 4'hD, 0, 0, 0};

    reset = 1'b1; active_layer = 2'd0; layer_visible = 4'hF; tool_valid = 1'b0;
    tool_x = 3'd0; tool_y = 3'd0; tool_color = '0; clear_req = 1'b0; clear_layer = 2'd0;
    read_x = 3'd0; read_y = 3'd0;
    tick();
    tick();
    check("rst_color",  int'(pixel_color),  0);
    check("rst_opaque", int'(pixel_opaque), 0);
    check("rst_top",    int'(top_layer),    0);
    check("rst_busy",   int'(clear_busy),   0);
    reset = 1'b0;
    tick();

    for (int l = 0; l < 4; l++) clear_wait(l);

    // Build a small scene, including a write to a hidden layer that must be dropped.
    layer_visible = 4'hF;
    write_px(1, 3, 2, 5);
    write_px(0, 1, 1, 2);
    write_px(3, 1, 1, 6);
    write_px(2, 6, 6, 9);
    layer_visible = 4'b1011;
    write_px(2, 5, 5, 7);
    layer_visible = 4'hF;

    for (int i = 0; i < 9; i++)
      check_px($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].vis,
               vecs[i].ec, vecs[i].eo, vecs[i].et);

    // Back-to-back requests: one result per cycle, each 2 cycles after its request.
    exp_x = '{3, 1, 4, 6}; exp_y = '{2, 1, 2, 6};
    exp_c = '{5, 6, 0, 9}; exp_t = '{1, 3, 0, 2};
    layer_visible = 4'hF;
    for (int j = 0; j < 5; j++) begin
      if (j < 4) begin
        read_x = 3'(exp_x[j]);
        read_y = 3'(exp_y[j]);
      end
      tick();
      if (j >= 1) begin
        check($sformatf("pipe%0d_color", j - 1), int'(pixel_color), exp_c[j-1]);
        check($sformatf("pipe%0d_top", j - 1),   int'(top_layer),   exp_t[j-1]);
      end
    end

    // Same-edge write and read return old data; the next request sees the new color.
    active_layer = 2'd3; tool_x = 3'd2; tool_y = 3'd2; tool_color = 8'd8; tool_valid = 1'b1;
    read_x = 3'd2; read_y = 3'd2;
    tick();
    tool_valid = 1'b0;
    tick();
    check("rdw_old_color", int'(pixel_color), 0);
    tick();
    check("rdw_new_color", int'(pixel_color), 8);
    check("rdw_new_top",   int'(top_layer),   3);

    // Fill layer 1, then clear it with a second request and tool writes mid-sweep.
    for (int a = 0; a < 64; a++) write_px(1, a % 8, a / 8, a + 1);
    check_px("fill_l1", 7, 7, 4'b0010, 64, 1, 1);
    layer_visible = 4'hF;
    clear_layer = 2'd1;
    clear_req   = 1'b1;
    tick();
    check("sweep_busy_rise", int'(clear_busy), 1);
    cnt = 0;
    while (clear_busy && cnt < 200) begin
      cnt++;
      clear_req   = (cnt == 10);
      clear_layer = 2'd2;
      tool_valid  = (cnt == 20) || (cnt == 21) || (cnt == 40);
      if (cnt == 20) begin
        active_layer = 2'd1; tool_x = 3'd0; tool_y = 3'd7; tool_color = 8'd4;
      end else if (cnt == 21) begin
        active_layer = 2'd2; tool_x = 3'd0; tool_y = 3'd7; tool_color = 8'd11;
      end else if (cnt == 40) begin
        active_layer = 2'd1; tool_x = 3'd1; tool_y = 3'd0; tool_color = 8'd15;
      end else begin
        tool_color = 8'd0;
      end
      tick();
    end
    tool_valid = 1'b0;
    clear_req  = 1'b0;
    check("sweep_busy_cycles", cnt, 64);

    nonzero = 0;
    for (int a = 0; a < 64; a++) begin
      read_x = 3'(a % 8); read_y = 3'(a / 8); layer_visible = 4'b0010;
      tick();
      tick();
      if (pixel_opaque) nonzero++;
    end
    check("l1_opaque_after_clear", nonzero, 0);
    check_px("l2_concurrent", 0, 7, 4'b0100, 11, 1, 2);
    check_px("l2_not_cleared", 6, 6, 4'b0100, 9, 1, 2);

    // Reset in the middle of a sweep of layer 0 leaves addresses 20.. untouched.
    layer_visible = 4'hF;
    write_px(0, 3, 2, 12);
    write_px(0, 4, 2, 13);
    write_px(0, 0, 5, 14);
    read_x = 3'd1; read_y = 3'd1;
    tick();
    tick();
    check("pre_reset_color", int'(pixel_color), 6);
    clear_layer = 2'd0;
    clear_req   = 1'b1;
    tick();
    clear_req   = 1'b0;
    repeat (20) tick();
    check("mid_busy_before", int'(clear_busy), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy",   int'(clear_busy),   0);
    check("mid_rst_color",  int'(pixel_color),  0);
    check("mid_rst_opaque", int'(pixel_opaque), 0);
    check("mid_rst_top",    int'(top_layer),    0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_busy", int'(clear_busy), 0);
    check_px("addr19_cleared", 3, 2, 4'b0001, 0, 0, 0);
    check_px("addr20_kept",    4, 2, 4'b0001, 13, 1, 0);
    check_px("addr40_kept",    0, 5, 4'b0001, 14, 1, 0);
    check_px("l3_survives",    1, 1, 4'hF, 6, 1, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_stack.md
# layer_stack

Parametrised multi-layer drawing store and compositor for the paint pipeline. It holds NUM_LAYERS canvas memories and accepts freehand-tool pixel writes into the active layer. A per-layer clear is executed by an internal sweep state machine. For the VGA driver, it returns the top-most opaque pixel across visible layers through a fixed 2-cycle read pipeline.

## Interface
Parameters:
- WIDTH, 640, canvas width in pixels
- HEIGHT, 480, canvas height in pixels
- NUM_LAYERS, 4, number of canvas layers (≥2); layer NUM_LAYERS-1 is top

Ports:
- clk  in  1  system clock (CLOCK_50 domain); the block has one clock
- reset  in  1  asynchronous, active-high reset
- active_layer  in  $clog2(NUM_LAYERS)  layer receiving tool writes
- layer_visible  in  NUM_LAYERS  per-layer visibility mask
- tool_valid  in  1  tool pixel write strobe
- tool_x / tool_y  in  $clog2(WIDTH) / $clog2(HEIGHT)  tool pixel coordinate
- tool_color  in  COLOR_WIDTH  tool pixel color
- clear_req  in  1  one-cycle clear request
- clear_layer  in  $clog2(NUM_LAYERS)  layer to clear, sampled with clear_req
- clear_busy  out  1  clear sweep in progress
- read_x / read_y  in  $clog2(WIDTH) / $clog2(HEIGHT)  VGA request coordinate, sampled every cycle
- pixel_color  out  COLOR_WIDTH  composited color
- pixel_opaque  out  1  some visible layer is non-transparent at this pixel
- top_layer  out  $clog2(NUM_LAYERS)  index of the layer supplying pixel_color

## Operation
- Addressing: addr = y*WIDTH + x, $clog2(WIDTH*HEIGHT) bits, no wrap. A coordinate with x≥WIDTH or y≥HEIGHT is out of range.
- Memory contents are not initialised by reset.
- Tool write:
  - Commits tool_color to layer active_layer when tool_valid=1, layer_visible[active_layer]=1, active_layer<NUM_LAYERS, and the coordinate is in range.
  - Otherwise the write is dropped.
- Clear FSM, two states:
  - IDLE: clear_req=1 with clear_layer<NUM_LAYERS latches the layer and zeroes the sweep counter, then goes to CLEAR. An out-of-range clear_layer is ignored.
  - CLEAR: writes COLOR_NONE to address counter, one address per cycle. When counter=WIDTH*HEIGHT-1 it returns to IDLE.
  - clear_req while in CLEAR is ignored, not queued.
- Simultaneous tool write and clear:
  - A tool write to the layer being cleared is dropped for the whole sweep.
  - Tool writes to other layers proceed unaffected.
- Read, stage 1: read_x/read_y and layer_visible are registered into all layer memories.
- Read, stage 2: the memory outputs are composited.
  - Scan from layer NUM_LAYERS-1 down to 0 and pick the first layer that is visible with color≠COLOR_NONE.
  - If none qualifies: pixel_color=COLOR_NONE, pixel_opaque=0, top_layer=0.
  - An out-of-range read coordinate yields COLOR_NONE, pixel_opaque=0.
- Read-during-write at the same address in the same cycle returns old data.

## Timing
- Reset values: pixel_color=COLOR_NONE, pixel_opaque=0, top_layer=0, clear_busy=0, FSM=IDLE, counter=0.
- Read latency: exactly 2 cycles, fully pipelined, one pixel per cycle. A request at edge n appears on the outputs after edge n+2.
- Tool write: committed at the edge where it is sampled; readable by a request issued on the next cycle.
- clear_busy: rises the cycle after clear_req is accepted and stays high for exactly WIDTH*HEIGHT cycles. It falls the cycle after the last address is written.
- Reset mid-clear: the FSM returns to IDLE immediately and clear_busy drops. The layer is left partially cleared; no resume.

## Structure
- COLOR_WIDTH and COLOR_NONE (=0) come from the shared common package; no new package types.
- Sub-module: layer_memory, one instance per layer via generate.
  - One synchronous write port and one registered read port, WIDTH*HEIGHT × COLOR_WIDTH.
  - The write-port mux between tool and clear sweep lives in layer_stack.
- The clear FSM state is a typedef enum local to layer_stack.

## Test plan
All scenarios use WIDTH=8, HEIGHT=8, NUM_LAYERS=4; all layers are cleared first.
- Basic write/read: pulse reset, all visible; tool write (3,2) color 5 on layer 1; read (3,2) → 2 cycles later pixel_color=5, pixel_opaque=1, top_layer=1. Read (4,2) → COLOR_NONE, opaque=0.
- Priority: write (1,1) color 2 on layer 0 and color 6 on layer 3 → read gives 6, top_layer=3. Clear layer_visible[3] → read gives 2, top_layer=0.
- Hidden/invalid writes: layer_visible[2]=0, write to layer 2 → later read with layer 2 visible gives COLOR_NONE. A write at x=9 (only if the port width allows) changes nothing.
- Clear sweep: fill layer 1; pulse clear_req on layer 1 → clear_busy high exactly 64 cycles. Every address of layer 1 reads COLOR_NONE afterwards; a second clear_req at cycle 10 is ignored (busy still 64 total).
- Clear with concurrent writes: during the clear of layer 1, tool writes to layer 1 at (0,7) and to layer 2 at (0,7) → after the sweep, layer 1 is NONE and layer 2 holds the written color.
- Reset mid-clear: assert reset at sweep cycle 20 → clear_busy=0 and outputs at reset values within the same cycle. Addresses 0–19 are cleared; address 40 keeps its old color.
